// File: rtl/bin_bbox_overlay_if.sv
// Stream bundle for the bounding-box overlay block: the cleaned binary
// stream coming in, the overlaid stream and committed box going out.
interface bin_bbox_overlay_if;
  logic        bina_hsync;
  logic        bina_vsync;
  logic [7:0]  bina_data;
  logic        bina_de;

  logic        box_hsync;
  logic        box_vsync;
  logic [7:0]  box_data;
  logic        box_de;
  logic        box_valid;
  logic [9:0]  box_xmin;
  logic [9:0]  box_xmax;
  logic [9:0]  box_ymin;
  logic [9:0]  box_ymax;
  logic [18:0] box_count;

  // Source side: drives the binary stream, observes the overlay results.
  modport master (
    output bina_hsync, bina_vsync, bina_data, bina_de,
    input  box_hsync, box_vsync, box_data, box_de, box_valid,
    input  box_xmin, box_xmax, box_ymin, box_ymax, box_count
  );

  // Block side: consumes the binary stream, produces the overlay results.
  modport slave (
    input  bina_hsync, bina_vsync, bina_data, bina_de,
    output box_hsync, box_vsync, box_data, box_de, box_valid,
    output box_xmin, box_xmax, box_ymin, box_ymax, box_count
  );
endinterface

// File: rtl/bin_bbox_overlay.sv
// Measures the bounding box and pixel count of the foreground in each
// binary frame, commits it at the next vsync, and draws the committed
// rectangle onto the following frame's pass-through stream.
module bin_bbox_overlay #(
  parameter int         H_DISP     = 640,
  parameter int         V_DISP     = 480,
  parameter logic [7:0] FG_VALUE   = 8'd255,
  parameter logic [7:0] BOX_VALUE  = 8'd128,
  parameter int         MIN_PIXELS = 16
) (
  input logic               clk,
  input logic               rst,
  bin_bbox_overlay_if.slave io
);

  localparam logic [9:0]  X_LAST  = 10'(H_DISP - 1);
  localparam logic [9:0]  Y_LAST  = 10'(V_DISP - 1);
  localparam logic [18:0] CNT_MAX = '1;
  localparam logic [18:0] MIN_CNT = 19'(MIN_PIXELS);

  typedef enum logic [1:0] {
    WAIT_FRAME,
    ACTIVE,
    COMMIT
  } state_t;

  state_t      state_q, state_d;

  logic        hsync_q, vsync_q, de_q;
  logic [7:0]  data_q, data_d;

  logic [9:0]  xPos_q, xPos_d;
  logic [9:0]  yPos_q, yPos_d;

  logic [9:0]  accXmin_q, accXmin_d;
  logic [9:0]  accXmax_q, accXmax_d;
  logic [9:0]  accYmin_q, accYmin_d;
  logic [9:0]  accYmax_q, accYmax_d;
  logic [18:0] accCnt_q, accCnt_d;

  logic        boxValid_q, boxValid_d;
  logic [9:0]  boxXmin_q, boxXmin_d;
  logic [9:0]  boxXmax_q, boxXmax_d;
  logic [9:0]  boxYmin_q, boxYmin_d;
  logic [9:0]  boxYmax_q, boxYmax_d;
  logic [18:0] boxCount_q, boxCount_d;

  logic        vsyncRise;
  logic        deFall;
  logic        fgHit;
  logic        onCol;
  logic        onRow;

  // The delayed sync/de registers double as the previous-cycle samples for edge detection.
  assign vsyncRise = io.bina_vsync & ~vsync_q;
  assign deFall    = ~io.bina_de & de_q;
  assign fgHit     = io.bina_de && (io.bina_data == FG_VALUE);

  // Pixel coordinates of the current input sample, saturating so oversize timing never wraps.
  always_comb begin
    xPos_d = '0;
    yPos_d = yPos_q;
    if (io.bina_de) begin
      xPos_d = (xPos_q == X_LAST) ? xPos_q : xPos_q + 10'd1;
    end
    if (vsyncRise) begin
      yPos_d = '0;
    end else if (deFall && (yPos_q != Y_LAST)) begin
      yPos_d = yPos_q + 10'd1;
    end
  end

  // Frame state machine: accumulate the box during a frame, commit it for one cycle at vsync.
  always_comb begin
    state_d    = state_q;
    accXmin_d  = accXmin_q;
    accXmax_d  = accXmax_q;
    accYmin_d  = accYmin_q;
    accYmax_d  = accYmax_q;
    accCnt_d   = accCnt_q;
    boxValid_d = boxValid_q;
    boxXmin_d  = boxXmin_q;
    boxXmax_d  = boxXmax_q;
    boxYmin_d  = boxYmin_q;
    boxYmax_d  = boxYmax_q;
    boxCount_d = boxCount_q;
    case (state_q)
      WAIT_FRAME: begin
        if (vsyncRise) begin
          state_d   = ACTIVE;
          accXmin_d = X_LAST;
          accXmax_d = '0;
          accYmin_d = Y_LAST;
          accYmax_d = '0;
          accCnt_d  = '0;
        end
      end
      ACTIVE: begin
        if (vsyncRise) begin
          state_d = COMMIT;
        end else if (fgHit) begin
          accXmin_d = (xPos_q < accXmin_q) ? xPos_q : accXmin_q;
          accXmax_d = (xPos_q > accXmax_q) ? xPos_q : accXmax_q;
          accYmin_d = (yPos_q < accYmin_q) ? yPos_q : accYmin_q;
          accYmax_d = (yPos_q > accYmax_q) ? yPos_q : accYmax_q;
          accCnt_d  = (accCnt_q == CNT_MAX) ? accCnt_q : accCnt_q + 19'd1;
        end
      end
      COMMIT: begin
        boxValid_d = (accCnt_q >= MIN_CNT);
        boxXmin_d  = accXmin_q;
        boxXmax_d  = accXmax_q;
        boxYmin_d  = accYmin_q;
        boxYmax_d  = accYmax_q;
        boxCount_d = accCnt_q;
        accXmin_d  = X_LAST;
        accXmax_d  = '0;
        accYmin_d  = Y_LAST;
        accYmax_d  = '0;
        accCnt_d   = '0;
        state_d    = vsyncRise ? COMMIT : ACTIVE;
      end
      default: begin
        state_d = WAIT_FRAME;
      end
    endcase
  end

  // Overlay the previously committed rectangle perimeter onto the pass-through pixel.
  always_comb begin
    onCol  = ((xPos_q == boxXmin_q) || (xPos_q == boxXmax_q)) &&
             (yPos_q >= boxYmin_q) && (yPos_q <= boxYmax_q);
    onRow  = ((yPos_q == boxYmin_q) || (yPos_q == boxYmax_q)) &&
             (xPos_q >= boxXmin_q) && (xPos_q <= boxXmax_q);
    data_d = '0;
    if (io.bina_de) begin
      data_d = (boxValid_q && (onCol || onRow)) ? BOX_VALUE : io.bina_data;
    end
  end

  // All state and outputs register here; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WAIT_FRAME;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      de_q       <= 1'b0;
      data_q     <= '0;
      xPos_q     <= '0;
      yPos_q     <= '0;
      accXmin_q  <= X_LAST;
      accXmax_q  <= '0;
      accYmin_q  <= Y_LAST;
      accYmax_q  <= '0;
      accCnt_q   <= '0;
      boxValid_q <= 1'b0;
      boxXmin_q  <= '0;
      boxXmax_q  <= '0;
      boxYmin_q  <= '0;
      boxYmax_q  <= '0;
      boxCount_q <= '0;
    end else begin
      state_q    <= state_d;
      hsync_q    <= io.bina_hsync;
      vsync_q    <= io.bina_vsync;
      de_q       <= io.bina_de;
      data_q     <= data_d;
      xPos_q     <= xPos_d;
      yPos_q     <= yPos_d;
      accXmin_q  <= accXmin_d;
      accXmax_q  <= accXmax_d;
      accYmin_q  <= accYmin_d;
      accYmax_q  <= accYmax_d;
      accCnt_q   <= accCnt_d;
      boxValid_q <= boxValid_d;
      boxXmin_q  <= boxXmin_d;
      boxXmax_q  <= boxXmax_d;
      boxYmin_q  <= boxYmin_d;
      boxYmax_q  <= boxYmax_d;
      boxCount_q <= boxCount_d;
    end
  end

  assign io.box_hsync = hsync_q;
  assign io.box_vsync = vsync_q;
  assign io.box_de    = de_q;
  assign io.box_data  = data_q;
  assign io.box_valid = boxValid_q;
  assign io.box_xmin  = boxXmin_q;
  assign io.box_xmax  = boxXmax_q;
  assign io.box_ymin  = boxYmin_q;
  assign io.box_ymax  = boxYmax_q;
  assign io.box_count = boxCount_q;

endmodule

// File: tb/tb_bin_bbox_overlay.sv
// Bench for bin_bbox_overlay: drives short synthetic frames into two
// instances (default threshold, and MIN_PIXELS=1), predicts every output
// pixel through a scoreboard queue and checks committed boxes per frame.
module tb_bin_bbox_overlay;

  localparam int H_DISP = 640;
  localparam int V_DISP = 480;

  localparam int P_BG     = 0;
  localparam int P_BLOCK  = 1;
  localparam int P_ISO15  = 2;
  localparam int P_ISO16  = 3;
  localparam int P_ORIGIN = 4;
  localparam int P_CORNER = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hsDrv = 1'b0;
  logic       vsDrv = 1'b0;
  logic       deDrv = 1'b0;
  logic [7:0] dataDrv = 8'd0;

  int total = 0;
  int bad   = 0;

  // Free-running pixel clock.
  always #5 clk = ~clk;

  bin_bbox_overlay_if busA ();
  bin_bbox_overlay_if busB ();

  // Both instances see the identical input stream.
  assign busA.bina_hsync = hsDrv;
  assign busA.bina_vsync = vsDrv;
  assign busA.bina_de    = deDrv;
  assign busA.bina_data  = dataDrv;
  assign busB.bina_hsync = hsDrv;
  assign busB.bina_vsync = vsDrv;
  assign busB.bina_de    = deDrv;
  assign busB.bina_data  = dataDrv;

  bin_bbox_overlay dutA (
    .clk (clk),
    .rst (rst),
    .io  (busA)
  );

  bin_bbox_overlay #(.MIN_PIXELS(1)) dutB (
    .clk (clk),
    .rst (rst),
    .io  (busB)
  );

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [7:0] dA;
    logic [7:0] dB;
  } exp_t;

  typedef struct packed {
    logic        valid;
    logic [9:0]  xmin;
    logic [9:0]  xmax;
    logic [9:0]  ymin;
    logic [9:0]  ymax;
    logic [18:0] count;
  } box_t;

  exp_t sbQ[$];
  box_t mBox[2];
  int   minPix[2];
  int   accXmin, accXmax, accYmin, accYmax, accCnt;
  bit   armed;
  bit   prevVs;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clearAcc();
    accXmin = H_DISP - 1;
    accXmax = 0;
    accYmin = V_DISP - 1;
    accYmax = 0;
    accCnt  = 0;
  endtask

  function automatic bit onPerimeter(input box_t b, input int x, input int y);
    bit col, row;
    col = ((x == int'(b.xmin)) || (x == int'(b.xmax))) && (y >= int'(b.ymin)) && (y <= int'(b.ymax));
    row = ((y == int'(b.ymin)) || (y == int'(b.ymax))) && (x >= int'(b.xmin)) && (x <= int'(b.xmax));
    return b.valid && (col || row);
  endfunction

  function automatic logic [7:0] pixelVal(input int pat, input int x, input int y);
    bit fg;
    fg = 1'b0;
    case (pat)
      P_BLOCK:  fg = (x >= 100) && (x <= 119) && (y >= 50) && (y <= 59);
      P_ISO15:  fg = (y < 15) && (x == 7 * y);
      P_ISO16:  fg = (y < 16) && (x == 7 * y);
      P_ORIGIN: fg = (x == 0) && (y == 0);
      P_CORNER: fg = (x == 639) && (y == 479);
      default:  fg = 1'b0;
    endcase
    if (fg) return 8'd255;
    return (((x + 3 * y) % 11) == 5) ? 8'd1 : 8'd0;
  endfunction

  // Pops the prediction for the sample driven one cycle ago and compares it.
  task automatic checkOutput();
    exp_t e;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkEq("A_hsync", 32'(busA.box_hsync), 32'(e.hs));
      checkEq("A_vsync", 32'(busA.box_vsync), 32'(e.vs));
      checkEq("A_de",    32'(busA.box_de),    32'(e.de));
      checkEq("A_data",  32'(busA.box_data),  32'(e.dA));
      checkEq("B_hsync", 32'(busB.box_hsync), 32'(e.hs));
      checkEq("B_vsync", 32'(busB.box_vsync), 32'(e.vs));
      checkEq("B_de",    32'(busB.box_de),    32'(e.de));
      checkEq("B_data",  32'(busB.box_data),  32'(e.dB));
    end
  endtask

  // Drives one cycle of input, updates the frame model and queues the expected output.
  task automatic applyStimulus(input bit r, input bit hs, input bit vs, input bit de,
                               input logic [7:0] d, input int x, input int y);
    exp_t e;
    @(negedge clk);
    checkOutput();
    rst     = r;
    hsDrv   = hs;
    vsDrv   = vs;
    deDrv   = de;
    dataDrv = d;
    e = '0;
    if (r) begin
      mBox[0] = '0;
      mBox[1] = '0;
      armed   = 1'b0;
    end else begin
      e.hs = hs;
      e.vs = vs;
      e.de = de;
      e.dA = !de ? 8'd0 : (onPerimeter(mBox[0], x, y) ? 8'd128 : d);
      e.dB = !de ? 8'd0 : (onPerimeter(mBox[1], x, y) ? 8'd128 : d);
      if (vs && !prevVs) begin
        if (armed) begin
          for (int i = 0; i < 2; i++) begin
            mBox[i].valid = (accCnt >= minPix[i]);
            mBox[i].xmin  = 10'(accXmin);
            mBox[i].xmax  = 10'(accXmax);
            mBox[i].ymin  = 10'(accYmin);
            mBox[i].ymax  = 10'(accYmax);
            mBox[i].count = 19'(accCnt);
          end
        end
        armed = 1'b1;
        clearAcc();
      end else if (armed && de && (d == 8'd255)) begin
        if (x < accXmin) accXmin = x;
        if (x > accXmax) accXmax = x;
        if (y < accYmin) accYmin = y;
        if (y > accYmax) accYmax = y;
        accCnt++;
      end
    end
    prevVs = r ? 1'b0 : vs;
    sbQ.push_back(e);
  endtask

  task automatic checkBoxOf(input string tag, input logic v, input logic [9:0] xmn,
                            input logic [9:0] xmx, input logic [9:0] ymn,
                            input logic [9:0] ymx, input logic [18:0] cnt, input box_t m);
    checkEq({tag, "_valid"}, 32'(v),   32'(m.valid));
    checkEq({tag, "_xmin"},  32'(xmn), 32'(m.xmin));
    checkEq({tag, "_xmax"},  32'(xmx), 32'(m.xmax));
    checkEq({tag, "_ymin"},  32'(ymn), 32'(m.ymin));
    checkEq({tag, "_ymax"},  32'(ymx), 32'(m.ymax));
    checkEq({tag, "_count"}, 32'(cnt), 32'(m.count));
  endtask

  task automatic checkCommitted(input string tag);
    checkBoxOf({tag, "_A"}, busA.box_valid, busA.box_xmin, busA.box_xmax,
               busA.box_ymin, busA.box_ymax, busA.box_count, mBox[0]);
    checkBoxOf({tag, "_B"}, busB.box_valid, busB.box_xmin, busB.box_xmax,
               busB.box_ymin, busB.box_ymax, busB.box_count, mBox[1]);
  endtask

  task automatic sendVsync();
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 8'd0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 8'd0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 8'd0, 0, 0);
  endtask

  // One frame of lines; optionally pulses reset on pixel (rstX, rstLine).
  task automatic sendFrame(input int pat, input int nLines, input int len, input int lastLen,
                           input int rstLine, input int rstX);
    int  lineLen;
    bit  pending;
    bit  r;
    pending = 1'b0;
    for (int y = 0; y < nLines; y++) begin
      lineLen = (y == nLines - 1) ? lastLen : len;
      for (int x = 0; x < lineLen; x++) begin
        r = (y == rstLine) && (x == rstX);
        applyStimulus(r, 0, 0, 1, pixelVal(pat, x, y), x, y);
        if (pending) begin
          pending = 1'b0;
          checkCommitted("after_rst");
          checkEq("after_rst_valid", 32'(busA.box_valid), 32'd0);
        end
        if (r) pending = 1'b1;
      end
      for (int b = 0; b < 4; b++) applyStimulus(0, (b == 1) || (b == 2), 0, 0, 8'd0, 0, y);
    end
  endtask

  initial begin
    minPix[0] = 16;
    minPix[1] = 1;
    mBox[0]   = '0;
    mBox[1]   = '0;
    armed     = 1'b0;
    prevVs    = 1'b0;
    clearAcc();
    $display("[TB] start");

    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 8'd0, 0, 0);
    applyStimulus(0, 0, 0, 0, 8'd0, 0, 0);
    checkCommitted("reset");

    sendFrame(P_BLOCK, 30, 120, 120, -1, 0);
    sendVsync();
    checkCommitted("arm");

    sendFrame(P_BG, 16, 32, 32, -1, 0);
    sendVsync();
    checkCommitted("bg");
    checkEq("bg_valid", 32'(busA.box_valid), 32'd0);
    checkEq("bg_count", 32'(busA.box_count), 32'd0);

    sendFrame(P_BLOCK, 60, 120, 120, -1, 0);
    sendVsync();
    checkCommitted("block1");
    checkEq("block1_xmin",  32'(busA.box_xmin),  32'd100);
    checkEq("block1_xmax",  32'(busA.box_xmax),  32'd119);
    checkEq("block1_ymin",  32'(busA.box_ymin),  32'd50);
    checkEq("block1_ymax",  32'(busA.box_ymax),  32'd59);
    checkEq("block1_count", 32'(busA.box_count), 32'd200);
    checkEq("block1_valid", 32'(busA.box_valid), 32'd1);

    sendFrame(P_BLOCK, 60, 120, 120, -1, 0);
    sendVsync();
    checkCommitted("block2");

    sendFrame(P_BLOCK, 60, 120, 120, 30, 5);
    sendVsync();
    checkCommitted("rst_arm");
    checkEq("rst_arm_count", 32'(busA.box_count), 32'd0);

    sendFrame(P_BLOCK, 60, 120, 120, -1, 0);
    sendVsync();
    checkCommitted("post_rst");
    checkEq("post_rst_count", 32'(busA.box_count), 32'd200);
    checkEq("post_rst_valid", 32'(busA.box_valid), 32'd1);

    sendFrame(P_ISO15, 16, 112, 112, -1, 0);
    sendVsync();
    checkCommitted("iso15");
    checkEq("iso15_A_valid", 32'(busA.box_valid), 32'd0);
    checkEq("iso15_A_count", 32'(busA.box_count), 32'd15);
    checkEq("iso15_B_valid", 32'(busB.box_valid), 32'd1);

    sendFrame(P_ISO16, 16, 112, 112, -1, 0);
    sendVsync();
    checkCommitted("iso16");
    checkEq("iso16_A_valid", 32'(busA.box_valid), 32'd1);

    sendFrame(P_ORIGIN, 16, 32, 32, -1, 0);
    sendVsync();
    checkCommitted("origin");
    checkEq("origin_B_xmax", 32'(busB.box_xmax), 32'd0);
    checkEq("origin_B_ymax", 32'(busB.box_ymax), 32'd0);

    sendFrame(P_CORNER, V_DISP, 1, H_DISP, -1, 0);
    sendVsync();
    checkCommitted("corner");
    checkEq("corner_B_xmin", 32'(busB.box_xmin), 32'd639);
    checkEq("corner_B_ymin", 32'(busB.box_ymin), 32'd479);

    sendFrame(P_BG, V_DISP, 1, H_DISP, -1, 0);
    sendVsync();
    checkCommitted("final");

    applyStimulus(0, 0, 0, 0, 8'd0, 0, 0);
    applyStimulus(0, 0, 0, 0, 8'd0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
